mcpu_program_loader: RTL

- Parametrised boot/program loader for the MCPU: streams instruction words into the CPU's RAM over a valid/ready handshake, then releases the CPU from reset.
- Optionally zero-fills the RAM first, keeps a word count and modular checksum, and traps oversize images.
- Replaces hierarchical memory and register pokes in benches; in silicon it sits between a host/debug port and the RAM write port.

---
 rtl/mcpu_program_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mcpu_program_loader.sv
// ============================================================================
// Module      : mcpu_program_loader
// Description : Boot loader that streams an instruction image into MCPU RAM
//               over valid/ready, then releases the core from reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcpu_program_loader #(
    parameter int WORD_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_START = 1,
    parameter int HOLD_CYCLES    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic [WORD_WIDTH-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_HOLD  = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX    = '1;
    localparam logic [ADDR_WIDTH:0]   WORDS_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [3:0]            HOLD_LAST   = 4'(HOLD_CYCLES - 1);
    localparam state_t                START_STATE = (CLEAR_ON_START != 0) ? S_CLEAR : S_LOAD;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            hold_cnt;
    logic                  handshake;

    assign handshake = in_valid & (state == S_LOAD);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_reset  = 1'b1;
        case (state)
            S_IDLE: begin
                if (start) state_next = START_STATE;
            end
            S_CLEAR: begin
                busy = 1'b1;
                if (addr == ADDR_MAX) state_next = S_LOAD;
            end
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (handshake) begin
                    if (in_last)               state_next = S_HOLD;
                    else if (addr == ADDR_MAX) state_next = S_ERROR;
                end
            end
            S_HOLD: begin
                busy = 1'b1;
                if (hold_cnt == HOLD_LAST) state_next = S_RUN;
            end
            S_RUN: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) state_next = START_STATE;
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) state_next = START_STATE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // mem_* are registered, so every write lands one cycle after the cycle
    // that issued it; the last CLEAR / LOAD write shows up in the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            addr         <= '0;
            hold_cnt     <= '0;
            words_loaded <= '0;
            checksum     <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (start) begin
                        addr         <= '0;
                        words_loaded <= '0;
                        checksum     <= '0;
                    end
                end
                S_CLEAR: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr;
                    mem_wdata <= '0;
                    addr      <= addr + 1'b1;
                end
                S_LOAD: begin
                    hold_cnt <= '0;
                    if (handshake) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= in_data;
                        addr      <= addr + 1'b1;
                        checksum  <= checksum + in_data;
                        if (words_loaded != WORDS_MAX) words_loaded <= words_loaded + 1'b1;
                    end
                end
                S_HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
